freq_sweep_ctrl: RTL and testbench
==================================

// Module: freq_sweep_ctrl
// PURPOSE
//  Sequencer for the DDS frequency path. It steps the lookup-table Address from a start value to a stop value.
//  On each step it pulses FreqChng to reload the oscillator, waits for the oscillator to settle, then dwells.
//  It is an alternative driver of lookup_table.Address and oscillator.freqchange, alongside the manual rotary path.
//  It runs entirely in the Fg_CLK domain.
// PARAMETERS
//  ADDR_W      11  width of Address, StartAddr, StopAddr and StepSize
//  DWELL_W     16  width of the Dwell count
//  SETTLE_CYC  4   consecutive Ready=1 cycles required after a FreqChng pulse before dwelling (>=1)
// PORTS
//  Fg_CLK     in   1        sole clock
//  RESETn     in   1        synchronous reset, active-low
//  Start      in   1        1-cycle pulse: latch config, begin sweep
//  Abort      in   1        1-cycle pulse: end sweep immediately
//  StartAddr  in   ADDR_W   first table address
//  StopAddr   in   ADDR_W   last table address (< StartAddr means sweep down)
//  StepSize   in   ADDR_W   address increment per step (0 treated as 1)
//  Dwell      in   DWELL_W  cycles held at each point (0 treated as 1)
//  Ready      in   1        oscillator running/valid (from sampling_control)
//  Address    out  ADDR_W   table address to lookup_table
//  FreqChng   out  1        1-cycle pulse whenever Address changes
//  Busy       out  1        high from sweep start until DONE/IDLE
//  Done       out  1        1-cycle pulse when the sweep completes normally
// BEHAVIOUR
//  - Reset (RESETn=0 at an edge): state=IDLE, Address=0, FreqChng=0, Busy=0, Done=0, all counters=0.
//    Reset mid-sweep aborts without a Done pulse.
//  - All outputs are registered. Config is latched only on accepted Start; changes to the inputs while Busy are ignored.
//  - States:
//    - IDLE:
//      - Start=1 and Abort=0 -> SETTLE. Same edge: Address<=StartAddr, FreqChng<=1, Busy<=1,
//        dir<=up if StopAddr>=StartAddr else down.
//      - Start with Abort in the same cycle -> stay IDLE.
//    - SETTLE:
//      - settle counter clears on entry; it increments on each cycle with Ready=1 and clears on Ready=0.
//      - counter reaches SETTLE_CYC -> DWELL, load dwell counter with max(Dwell,1).
//    - DWELL: decrement each cycle, independent of Ready. On the cycle the counter=1:
//      - Address==StopAddr -> DONE.
//      - else -> SETTLE. Address<=next, FreqChng<=1.
//        up: next=min(Address+step, StopAddr); down: next=max(Address-step, StopAddr).
//        Compute in ADDR_W+1 bits. The sweep never overshoots StopAddr and never wraps past 0 or 2^ADDR_W-1.
//    - DONE: Done<=1 for exactly one cycle, Busy<=0, -> IDLE. Address holds StopAddr.
//  - Abort=1 in SETTLE/DWELL/DONE: next state IDLE, Busy<=0, Done=0, Address holds its current value, no FreqChng.
//    Abort takes priority over every other transition.
//  - Start while Busy is ignored. Start in DONE is ignored.
//  - StartAddr==StopAddr: one point. Sequence is FreqChng, settle, dwell, then Done.
//  - FreqChng is never high on two consecutive cycles and is high only on the cycle after Address changes.
//  - Latency: Start sampled at edge N -> Address/FreqChng/Busy valid after edge N.
//    First DWELL cycle = N+SETTLE_CYC (Ready held 1).
//  - Timing per point with Ready=1: 1 + SETTLE_CYC + max(Dwell,1) - 1 cycles between successive FreqChng pulses.
// TESTING
//  - Reset: hold RESETn=0 2 cycles mid-sweep -> Address=0, Busy=0, FreqChng=0, Done=0; no Done pulse ever seen.
//  - Up sweep: Start=10, Stop=20, Step=4, Dwell=3, Ready=1 -> Address 10,14,18,20; 4 FreqChng pulses;
//    one Done; FreqChng spacing 7 cycles.
//  - Down sweep with clamp: Start=5, Stop=0, Step=3, Dwell=0 -> Address 5,2,0; Dwell treated as 1; no wrap to 2047.
//  - Settle stall: drop Ready for 3 cycles mid-SETTLE -> counter restarts; DWELL entered SETTLE_CYC cycles after Ready returns.
//  - Abort at the 2nd dwell cycle of point 14 -> Busy=0 next cycle, Address stays 14, no Done.
//    A new Start the following cycle is accepted.
//  - Start=Stop=2047, Step=0 -> one FreqChng, Done; Start pulsed while Busy is ignored; Start+Abort in IDLE stays IDLE.

Source files
------------

// File: rtl/freq_sweep_ctrl_if.sv
// Sweep controller bus: configuration and control towards the sequencer,
// table address and status back from it.
//   master: drives Start/Abort/StartAddr/StopAddr/StepSize/Dwell/Ready,
//           observes Address/FreqChng/Busy/Done
//   slave : the sequencer side
interface freq_sweep_ctrl_if #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DWELL_W = 16
);
    logic               Start;
    logic               Abort;
    logic [ADDR_W-1:0]  StartAddr;
    logic [ADDR_W-1:0]  StopAddr;
    logic [ADDR_W-1:0]  StepSize;
    logic [DWELL_W-1:0] Dwell;
    logic               Ready;
    logic [ADDR_W-1:0]  Address;
    logic               FreqChng;
    logic               Busy;
    logic               Done;

    modport master (
        output Start, Abort, StartAddr, StopAddr, StepSize, Dwell, Ready,
        input  Address, FreqChng, Busy, Done
    );

    modport slave (
        input  Start, Abort, StartAddr, StopAddr, StepSize, Dwell, Ready,
        output Address, FreqChng, Busy, Done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// DDS frequency sweep sequencer. Steps the lookup-table address from StartAddr
// to StopAddr by StepSize, pulsing FreqChng on every address change, waiting
// for SETTLE_CYC consecutive Ready cycles, then dwelling before the next step.
// Ports:
//   Fg_CLK  - sole clock
//   RESETn  - synchronous active-low reset
//   bus     - slave side of freq_sweep_ctrl_if (config/control in, Address,
//             FreqChng, Busy, Done out; all outputs registered)
module freq_sweep_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic               Fg_CLK,
    input  logic               RESETn,
    freq_sweep_ctrl_if.slave   bus
);

    // Counter only has to hold 0..SETTLE_CYC-1; the final Ready cycle moves on.
    localparam int unsigned SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic               freq_chng_q, freq_chng_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [ADDR_W-1:0]  stop_q, stop_d;
    logic [ADDR_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_up_q, dir_up_d;

    logic               start_ok_c;
    logic               settle_done_c;
    logic               last_dwell_c;
    logic               at_stop_c;
    logic [ADDR_W:0]    sum_c;
    logic [ADDR_W:0]    diff_c;
    logic [ADDR_W-1:0]  next_addr_c;

    assign start_ok_c    = bus.Start && !bus.Abort;
    assign settle_done_c = bus.Ready && (settle_cnt_q == SET_W'(SETTLE_CYC - 1));
    assign last_dwell_c  = (dwell_cnt_q == DWELL_W'(1));
    assign at_stop_c     = (address_q == stop_q);

    // Next point, clamped to StopAddr; the extra bit catches carry/borrow.
    always_comb begin
        sum_c  = {1'b0, address_q} + {1'b0, step_q};
        diff_c = {1'b0, address_q} - {1'b0, step_q};
        if (dir_up_q) begin
            next_addr_c = (sum_c >= {1'b0, stop_q}) ? stop_q : sum_c[ADDR_W-1:0];
        end else begin
            next_addr_c = (diff_c[ADDR_W] || (diff_c[ADDR_W-1:0] <= stop_q))
                          ? stop_q : diff_c[ADDR_W-1:0];
        end
    end

    // State register
    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Abort wins over every transition out of a busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.Abort)          state_d = ST_IDLE;
                else if (settle_done_c) state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (bus.Abort)         state_d = ST_IDLE;
                else if (last_dwell_c) state_d = at_stop_c ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        address_d    = address_q;
        freq_chng_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        dir_up_d     = dir_up_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    address_d    = bus.StartAddr;
                    freq_chng_d  = 1'b1;
                    busy_d       = 1'b1;
                    settle_cnt_d = '0;
                    stop_d       = bus.StopAddr;
                    step_d       = (bus.StepSize == '0) ? ADDR_W'(1) : bus.StepSize;
                    dwell_d      = (bus.Dwell == '0) ? DWELL_W'(1) : bus.Dwell;
                    dir_up_d     = (bus.StopAddr >= bus.StartAddr);
                end
            end
            ST_SETTLE: begin
                if (bus.Abort) begin
                    busy_d = 1'b0;
                end else if (!bus.Ready) begin
                    settle_cnt_d = '0;
                end else if (settle_done_c) begin
                    settle_cnt_d = '0;
                    dwell_cnt_d  = dwell_q;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_DWELL: begin
                if (bus.Abort) begin
                    busy_d = 1'b0;
                end else if (last_dwell_c) begin
                    dwell_cnt_d = '0;
                    if (!at_stop_c) begin
                        address_d    = next_addr_c;
                        freq_chng_d  = 1'b1;
                        settle_cnt_d = '0;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = !bus.Abort;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            address_q    <= '0;
            freq_chng_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            dir_up_q     <= 1'b0;
        end else begin
            address_q    <= address_d;
            freq_chng_q  <= freq_chng_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            dir_up_q     <= dir_up_d;
        end
    end

    assign bus.Address  = address_q;
    assign bus.FreqChng = freq_chng_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: reset, up/down sweeps with clamping,
// settle stall, abort/restart, single-point top-of-range sweep.
module tb_freq_sweep_ctrl;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DWELL_W    = 16;
    localparam int unsigned SETTLE_CYC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    freq_sweep_ctrl_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) bus ();

    freq_sweep_ctrl #(
        .ADDR_W     (ADDR_W),
        .DWELL_W    (DWELL_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .Fg_CLK (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Event log of the DUT outputs, sampled on the falling edge
    int                cyc = 0;
    int                fc_cyc[$];
    logic [ADDR_W-1:0] fc_addr[$];
    int                done_cnt = 0;
    int                consec   = 0;
    logic              fc_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.FreqChng) begin
            fc_cyc.push_back(cyc);
            fc_addr.push_back(bus.Address);
        end
        if (bus.Done) done_cnt++;
        if (bus.FreqChng && fc_prev) consec++;
        fc_prev = bus.FreqChng;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] so,
                               input logic [ADDR_W-1:0] st, input logic [DWELL_W-1:0] dw);
        bus.StartAddr = sa;
        bus.StopAddr  = so;
        bus.StepSize  = st;
        bus.Dwell     = dw;
        bus.Start     = 1'b1;
        @(negedge clk);
        bus.Start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.Done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 32'(bus.Done), 1);
    endtask

    task automatic clear_log();
        fc_cyc.delete();
        fc_addr.delete();
    endtask

    int up_exp[4] = '{10, 14, 18, 20};
    int dn_exp[3] = '{5, 2, 0};
    int base;
    int k;

    initial begin
        bus.Start     = 1'b0;
        bus.Abort     = 1'b0;
        bus.StartAddr = '0;
        bus.StopAddr  = '0;
        bus.StepSize  = '0;
        bus.Dwell     = '0;
        bus.Ready     = 1'b1;
        rst_n         = 1'b0;
        tick(2);
        check("rst_addr", 32'(bus.Address), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_fc",   32'(bus.FreqChng), 0);
        check("rst_done", 32'(bus.Done), 0);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of a sweep
        pulse_start(10, 20, 4, 3);
        tick(6);
        rst_n = 1'b0;
        tick(2);
        check("mr_addr", 32'(bus.Address), 0);
        check("mr_busy", 32'(bus.Busy), 0);
        check("mr_fc",   32'(bus.FreqChng), 0);
        check("mr_done", 32'(bus.Done), 0);
        rst_n = 1'b1;
        tick(40);
        check("mr_no_done", 32'(done_cnt), 0);
        check("mr_idle",    32'(bus.Busy), 0);

        // Up sweep 10 -> 20 step 4, dwell 3
        clear_log();
        base = done_cnt;
        pulse_start(10, 20, 4, 3);
        check("up_first_addr", 32'(bus.Address), 10);
        check("up_first_fc",   32'(bus.FreqChng), 1);
        check("up_busy",       32'(bus.Busy), 1);
        wait_done("up");
        check("up_busy_at_done", 32'(bus.Busy), 0);
        check("up_final_addr",   32'(bus.Address), 20);
        tick(1);
        check("up_fc_count", 32'(fc_addr.size()), 4);
        for (int i = 0; i < 4; i++) check($sformatf("up_addr%0d", i), 32'(fc_addr[i]), 32'(up_exp[i]));
        for (int i = 0; i < 3; i++) check($sformatf("up_space%0d", i), 32'(fc_cyc[i+1] - fc_cyc[i]), 7);
        check("up_done_count", 32'(done_cnt - base), 1);

        // Down sweep 5 -> 0 step 3, dwell 0 (treated as 1), clamps at 0
        clear_log();
        base = done_cnt;
        pulse_start(5, 0, 3, 0);
        wait_done("dn");
        check("dn_final_addr", 32'(bus.Address), 0);
        tick(1);
        check("dn_fc_count", 32'(fc_addr.size()), 3);
        for (int i = 0; i < 3; i++) check($sformatf("dn_addr%0d", i), 32'(fc_addr[i]), 32'(dn_exp[i]));
        for (int i = 0; i < 2; i++) check($sformatf("dn_space%0d", i), 32'(fc_cyc[i+1] - fc_cyc[i]), 5);
        check("dn_done_count", 32'(done_cnt - base), 1);

        // Settle stall: Ready low 3 cycles after 2 good ones restarts the count
        clear_log();
        pulse_start(7, 7, 1, 2);
        tick(2);
        bus.Ready = 1'b0;
        tick(3);
        check("stall_busy", 32'(bus.Busy), 1);
        bus.Ready = 1'b1;
        k = 5;
        while (!bus.Done && k < 40) begin
            tick(1);
            k++;
        end
        check("stall_done_lat", 32'(k), 12);
        tick(1);
        check("stall_fc_count", 32'(fc_addr.size()), 1);

        // Abort on the 2nd dwell cycle of point 14, then immediate restart
        clear_log();
        base = done_cnt;
        pulse_start(10, 20, 4, 3);
        k = 0;
        while (!(bus.FreqChng && bus.Address == 14) && k < 50) begin
            tick(1);
            k++;
        end
        check("ab_reach14", 32'(bus.Address), 14);
        tick(5);
        bus.Abort = 1'b1;
        tick(1);
        bus.Abort = 1'b0;
        check("ab_busy", 32'(bus.Busy), 0);
        check("ab_addr", 32'(bus.Address), 14);
        check("ab_fc",   32'(bus.FreqChng), 0);
        pulse_start(30, 30, 1, 1);
        check("rs_busy", 32'(bus.Busy), 1);
        check("rs_addr", 32'(bus.Address), 30);
        check("rs_fc",   32'(bus.FreqChng), 1);
        wait_done("rs");
        tick(1);
        check("ab_done_count", 32'(done_cnt - base), 1);
        check("ab_fc_count",   32'(fc_addr.size()), 3);

        // Top-of-range single point, step 0, Start while busy ignored
        clear_log();
        base = done_cnt;
        pulse_start(2047, 2047, 0, 2);
        check("top_addr", 32'(bus.Address), 2047);
        check("top_fc",   32'(bus.FreqChng), 1);
        tick(2);
        pulse_start(5, 9, 1, 1);
        check("top_ign_addr", 32'(bus.Address), 2047);
        check("top_ign_fc",   32'(bus.FreqChng), 0);
        wait_done("top");
        check("top_final_addr", 32'(bus.Address), 2047);
        tick(1);
        check("top_fc_count",   32'(fc_addr.size()), 1);
        check("top_done_count", 32'(done_cnt - base), 1);

        // Start together with Abort while idle does nothing
        bus.Start = 1'b1;
        bus.Abort = 1'b1;
        tick(1);
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        check("sa_busy", 32'(bus.Busy), 0);
        check("sa_fc",   32'(bus.FreqChng), 0);
        tick(5);
        check("sa_still_idle", 32'(bus.Busy), 0);
        check("fc_never_back_to_back", 32'(consec), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
